// File: rtl/async_fifo_lvl.sv
// Dual-clock FIFO with gray-pointer CDC, fill levels, almost flags and registered read data.
// Optional sticky overflow/underflow error flags are built when ASYNC_FIFO_ERR_FLAGS_EN is defined.
module async_fifo_lvl #(
  parameter int unsigned DATA_WIDTH    = 41,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned AFULL_THRESH  = 12,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  wr_overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  rd_underflow
);

  localparam int unsigned PW    = ADDR_WIDTH + 1;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write-domain state
  logic [PW-1:0] wr_ptr_bin;
  logic [PW-1:0] wr_ptr_gray;
  logic [PW-1:0] rd_gray_sync [SYNC_STAGES];

  // Read-domain state
  logic [PW-1:0] rd_ptr_bin;
  logic [PW-1:0] rd_ptr_gray;
  logic [PW-1:0] wr_gray_sync [SYNC_STAGES];

  logic          wr_accept;
  logic [PW-1:0] wr_bin_next;
  logic [PW-1:0] wr_gray_next;
  logic [PW-1:0] rd_sync_g;
  logic [PW-1:0] wr_level_next;
  logic          full_next;

  logic          rd_accept;
  logic [PW-1:0] rd_bin_next;
  logic [PW-1:0] rd_gray_next;
  logic [PW-1:0] wr_sync_g;
  logic [PW-1:0] rd_level_next;
  logic          empty_next;

  // Write-side next-state: full when the synced read pointer is exactly one lap behind.
  always_comb begin
    wr_accept     = wr_en & ~full;
    wr_bin_next   = wr_ptr_bin + PW'(wr_accept);
    wr_gray_next  = bin2gray(wr_bin_next);
    rd_sync_g     = rd_gray_sync[SYNC_STAGES-1];
    wr_level_next = wr_bin_next - gray2bin(rd_sync_g);
    full_next     = (wr_gray_next == {~rd_sync_g[PW-1:PW-2], rd_sync_g[PW-3:0]});
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wr_ptr_bin  <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        rd_gray_sync[i] <= '0;
      end
    end else begin
      wr_ptr_bin      <= wr_bin_next;
      wr_ptr_gray     <= wr_gray_next;
      full            <= full_next;
      wr_level        <= wr_level_next;
      almost_full     <= (wr_level_next >= PW'(AFULL_THRESH));
      rd_gray_sync[0] <= rd_ptr_gray;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        rd_gray_sync[i] <= rd_gray_sync[i-1];
      end
    end
  end

  // Storage is intentionally unreset.
  always_ff @(posedge wr_clk) begin
    if (wr_accept) begin
      mem[wr_ptr_bin[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  // Read-side next-state: empty when the next read pointer catches the synced write pointer.
  always_comb begin
    rd_accept     = rd_en & ~empty;
    rd_bin_next   = rd_ptr_bin + PW'(rd_accept);
    rd_gray_next  = bin2gray(rd_bin_next);
    wr_sync_g     = wr_gray_sync[SYNC_STAGES-1];
    rd_level_next = gray2bin(wr_sync_g) - rd_bin_next;
    empty_next    = (rd_gray_next == wr_sync_g);
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_ptr_bin   <= '0;
      rd_ptr_gray  <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_level     <= '0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        wr_gray_sync[i] <= '0;
      end
    end else begin
      rd_ptr_bin      <= rd_bin_next;
      rd_ptr_gray     <= rd_gray_next;
      empty           <= empty_next;
      rd_level        <= rd_level_next;
      almost_empty    <= (rd_level_next <= PW'(AEMPTY_THRESH));
      rd_valid        <= rd_accept;
      wr_gray_sync[0] <= wr_ptr_gray;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        wr_gray_sync[i] <= wr_gray_sync[i-1];
      end
      if (rd_accept) begin
        rd_data <= mem[rd_ptr_bin[ADDR_WIDTH-1:0]];
      end
    end
  end

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  // Sticky misuse flags, cleared only by their own domain reset.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      wr_overflow <= 1'b0;
    end else if (wr_en && full) begin
      wr_overflow <= 1'b1;
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      rd_underflow <= 1'b0;
    end else if (rd_en && empty) begin
      rd_underflow <= 1'b1;
    end
  end
`else
  assign wr_overflow  = 1'b0;
  assign rd_underflow = 1'b0;
`endif

endmodule
